mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-side RAM port among three requesters: core load/store (D), instruction-side prefetch or second-fetch (I), and an external loader/debug master (X).
- Grant is issued in the request cycle, with fixed priority D > I > X. An aging counter guarantees X service.
- A lock holds the port on D for split misaligned accesses.
- Sits between the core's memory access controller and the RAM's port 2. It returns read data one cycle later, tagged to the owning requester.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte enables are DW/8.
- MAX_WAIT, 8, cycles X may be denied before it is forced to top priority (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- d_req  in  1  D access request.
- d_lock  in  1  keep grant on D next cycle (first half of split access).
- d_addr  in  AW  D address.
- d_wdata  in  DW  D write data.
- d_we  in  DW/8  D byte write enables; 0 means read.
- d_gnt  out  1  D granted this cycle.
- d_rvalid  out  1  D read data valid.
- i_req / i_addr / i_gnt / i_rvalid  same widths as the D equivalents; I is read-only.
- x_req / x_addr / x_wdata / x_we / x_gnt / x_rvalid  same widths as the D equivalents.
- rdata  out  DW  shared read data, qualified by the *_rvalid signals.
- mem_ce  out  1  memory enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  DW/8  memory byte write enables.
- mem_rdata  in  DW  synchronous read data, valid one cycle after mem_ce.

Behaviour:
- Reset values:
  - owner_q = NONE, lock_q = 0, wait_cnt = 0.
  - all *_rvalid = 0.
  - Grants and mem_* are combinational; with no request they drive ce=0, we=0, addr=0, wdata=0.
- Priority, evaluated combinationally each cycle in this order:
  1. If lock_q=1: grant D if d_req, otherwise no grant (the port idles rather than going to I or X).
  2. Else if wait_cnt == MAX_WAIT and x_req: grant X.
  3. Else D > I > X.
- Exactly one *_gnt may be high per cycle (one-hot or zero).
- Granted requester's addr, wdata and we drive mem_*; mem_ce=1.
- I always drives mem_we=0.
- Lock:
  - lock_q <= d_gnt & d_lock.
  - A lock lasts at most one extra cycle per asserted d_lock. Chaining is allowed.
- Read response:
  - owner_q <= granted ID, but only if the grant was a read (we==0); otherwise NONE.
  - Next cycle, <owner>_rvalid=1 and rdata=mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads pipeline at one per cycle.
- Aging:
  - wait_cnt increments, saturating at MAX_WAIT, while x_req & ~x_gnt.
  - It clears when x_gnt or ~x_req.
  - A forced X grant overrides D and I, but never overrides lock_q.
- Requesters hold req, addr, wdata and we stable until gnt. The arbiter does not queue requests.
- Reset mid-transfer:
  - owner_q and lock_q clear immediately (asynchronous).
  - Any pending rvalid is lost.
  - The issuing requester re-requests after reset.
- FSM: two states, ARB (lock_q=0) and LOCKED (lock_q=1).
  - ARB -> LOCKED on d_gnt & d_lock.
  - LOCKED -> LOCKED on d_gnt & d_lock.
  - LOCKED -> ARB otherwise.

Decomposition:
- Shared package/header (define.vh): requester IDs as 2-bit constants, OWN_NONE=0, OWN_D=1, OWN_I=2, OWN_X=3. MAX_WAIT default macro.
- One natural sub-module, arb_age_cnt: the saturating wait counter with its force output.
- Everything else stays flat in mem_port_arbiter.

Test Plan:
- Priority:
  - Stimulus: d_req, i_req and x_req together, all reads, addr 0x100 / 0x200 / 0x300.
  - Response: d_gnt only, mem_addr=0x100; next cycle d_rvalid=1 with rdata from 0x100.
- Lock:
  - Stimulus: d_req+d_lock at 0x0FE, i_req held; next cycle d_req at 0x100 with no lock.
  - Response: D granted two consecutive cycles, i_gnt=0 throughout, I granted on the third cycle.
- Aging:
  - Stimulus: x_req held with d_req asserted continuously, MAX_WAIT=8.
  - Response: x_gnt=1 on the 9th cycle, then wait_cnt=0.
- Write, no response:
  - Stimulus: x_req with x_we=4'b0011, x_wdata=0xDEADBEEF at 0x40.
  - Response: mem_we=4'b0011 in the same cycle; no *_rvalid next cycle.
- Pipelined reads:
  - Stimulus: I reads 0x0, then D reads 0x8, then X reads 0xC, in consecutive cycles.
  - Response: i_rvalid, d_rvalid, x_rvalid in the following consecutive cycles, each exactly one cycle, with data matching.
- Async reset:
  - Stimulus: assert rst mid-cycle while lock_q=1 and a D read is pending.
  - Response: lock_q, owner_q and all rvalid go to 0 before the next clk edge; after release, I is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-side RAM port arbiter: requester IDs, lock FSM
// states and the default aging limit for the external master.
package mem_port_arbiter_pkg;

  localparam int MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2,
    OWN_X    = 2'd3
  } owner_e;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Requester ID to {x, i, d} one-hot; OWN_NONE maps to all-zero.
  function automatic logic [2:0] owner_onehot(input owner_e o);
    logic [2:0] oh;
    oh = 3'b000;
    case (o)
      OWN_D:   oh = 3'b001;
      OWN_I:   oh = 3'b010;
      OWN_X:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the port arbiter. The slave view belongs
// to the arbiter; the master view is the requesters plus the RAM.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  // Core load/store side
  logic          d_req;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_we;
  logic          d_gnt;
  logic          d_rvalid;

  // Instruction side, read-only
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;

  // External loader / debug master
  logic          x_req;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic [BW-1:0] x_we;
  logic          x_gnt;
  logic          x_rvalid;

  logic [DW-1:0] rdata;

  // RAM port
  logic          mem_ce;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  d_req, d_lock, d_addr, d_wdata, d_we,
    output d_gnt, d_rvalid,
    input  i_req, i_addr,
    output i_gnt, i_rvalid,
    input  x_req, x_addr, x_wdata, x_we,
    output x_gnt, x_rvalid,
    output rdata,
    output mem_ce, mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output d_req, d_lock, d_addr, d_wdata, d_we,
    input  d_gnt, d_rvalid,
    output i_req, i_addr,
    input  i_gnt, i_rvalid,
    output x_req, x_addr, x_wdata, x_we,
    input  x_gnt, x_rvalid,
    input  rdata,
    input  mem_ce, mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_age_cnt.sv
// Saturating count of consecutive cycles the external master was denied;
// force_x promotes X to top priority once the limit is reached.
module mem_port_arbiter_age_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic x_req,
  input  logic x_gnt,
  output logic force_x
);

  localparam logic [7:0] MAX_V = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (x_req && !x_gnt) begin
      if (wait_cnt != MAX_V) wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign force_x = x_req && (wait_cnt == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-cycle arbiter for the data-side RAM port: D > I > X with X aging,
// a one-cycle D lock for split accesses, and tagged one-cycle read return.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BW = DW / 8;

  arb_state_e    state_q;
  owner_e        owner_q;
  owner_e        sel;
  logic          force_x;
  logic          d_gnt;
  logic          i_gnt;
  logic          x_gnt;
  logic          is_read;
  logic          ce_mux;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic [BW-1:0] we_mux;

  mem_port_arbiter_age_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age_cnt (
    .clk     (clk),
    .rst     (rst),
    .x_req   (bus.x_req),
    .x_gnt   (x_gnt),
    .force_x (force_x)
  );

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel = OWN_NONE;
    if (state_q == ST_LOCKED) begin
      // A lock idles the port rather than letting I or X slip in.
      if (bus.d_req) sel = OWN_D;
    end else if (force_x) begin
      sel = OWN_X;
    end else if (bus.d_req) begin
      sel = OWN_D;
    end else if (bus.i_req) begin
      sel = OWN_I;
    end else if (bus.x_req) begin
      sel = OWN_X;
    end
  end

  always_comb begin
    ce_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = '0;
    case (sel)
      OWN_D: begin
        ce_mux    = 1'b1;
        addr_mux  = bus.d_addr;
        wdata_mux = bus.d_wdata;
        we_mux    = bus.d_we;
      end
      OWN_I: begin
        ce_mux    = 1'b1;
        addr_mux  = bus.i_addr;
      end
      OWN_X: begin
        ce_mux    = 1'b1;
        addr_mux  = bus.x_addr;
        wdata_mux = bus.x_wdata;
        we_mux    = bus.x_we;
      end
      default: ;
    endcase
  end

  assign {x_gnt, i_gnt, d_gnt} = owner_onehot(sel);
  assign is_read               = ce_mux && (we_mux == '0);

  // NOTE: async reset clears the lock and the read owner at once, so a read in
  // flight when reset hits never produces an rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARB;
      owner_q <= OWN_NONE;
    end else begin
      case (state_q)
        ST_ARB:    if (d_gnt && bus.d_lock) state_q <= ST_LOCKED;
        ST_LOCKED: if (!(d_gnt && bus.d_lock)) state_q <= ST_ARB;
        default:   state_q <= ST_ARB;
      endcase
      owner_q <= is_read ? sel : OWN_NONE;
    end
  end

  assign bus.d_gnt     = d_gnt;
  assign bus.i_gnt     = i_gnt;
  assign bus.x_gnt     = x_gnt;
  assign bus.mem_ce    = ce_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = we_mux;

  // Read data comes straight from the RAM; owner_q tags whose it is.
  assign {bus.x_rvalid, bus.i_rvalid, bus.d_rvalid} = owner_onehot(owner_q);
  assign bus.rdata = bus.mem_rdata;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0({x_gnt, i_gnt, d_gnt}));

  a_lock_holds : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_LOCKED) |-> !(i_gnt || x_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level reference
// model of the arbitration rules for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [2:0] gnt_v = {bus.x_gnt, bus.i_gnt, bus.d_gnt};
  wire [2:0] rv_v  = {bus.x_rvalid, bus.i_rvalid, bus.d_rvalid};

  // RAM contents are a fixed function of the address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1357};
  endfunction

  function automatic logic [2:0] oh(input int id);
    case (id)
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Synchronous-read RAM on port 2; a write cycle leaves the read register alone.
  always @(posedge clk) begin
    if (bus.mem_ce && bus.mem_we == '0) bus.mem_rdata <= pat(bus.mem_addr);
  end

  task automatic idle_inputs();
    bus.d_req = 0; bus.d_lock = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = '0;
    bus.i_req = 0; bus.i_addr = '0;
    bus.x_req = 0; bus.x_addr = '0; bus.x_wdata = '0; bus.x_we = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (gnt_v !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt_v); end
    checks++; if (rv_v !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b want 000", rv_v); end
    checks++; if (bus.mem_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", bus.mem_ce); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (bus.mem_we !== '0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    rst = 1'b0;
    step();
    checks++; if (rv_v !== 3'b000) begin errors++; $display("FAIL idle_rvalid: got %b want 000", rv_v); end
  endtask

  task automatic test_priority();
    bus.d_req = 1; bus.d_addr = 32'h100;
    bus.i_req = 1; bus.i_addr = 32'h200;
    bus.x_req = 1; bus.x_addr = 32'h300;
    #1;
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL prio_gnt: got %b want 001", gnt_v); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL prio_addr: got %h want 100", bus.mem_addr); end
    step();
    idle_inputs();
    checks++; if (rv_v !== 3'b001) begin errors++; $display("FAIL prio_rvalid: got %b want 001", rv_v); end
    checks++; if (bus.rdata !== pat(32'h100)) begin errors++; $display("FAIL prio_rdata: got %h want %h", bus.rdata, pat(32'h100)); end
    step();
  endtask

  task automatic test_lock();
    bus.d_req = 1; bus.d_lock = 1; bus.d_addr = 32'h0FE;
    bus.i_req = 1; bus.i_addr = 32'h200;
    #1;
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL lock_first: got %b want 001", gnt_v); end
    step();
    bus.d_lock = 0; bus.d_addr = 32'h100;
    checks++; if (rv_v !== 3'b001) begin errors++; $display("FAIL lock_rv1: got %b want 001", rv_v); end
    checks++; if (bus.rdata !== pat(32'h0FE)) begin errors++; $display("FAIL lock_rdata1: got %h want %h", bus.rdata, pat(32'h0FE)); end
    #1;
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL lock_second: got %b want 001", gnt_v); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL lock_addr2: got %h want 100", bus.mem_addr); end
    step();
    bus.d_req = 0;
    checks++; if (bus.rdata !== pat(32'h100)) begin errors++; $display("FAIL lock_rdata2: got %h want %h", bus.rdata, pat(32'h100)); end
    #1;
    checks++; if (gnt_v !== 3'b010) begin errors++; $display("FAIL lock_third_i: got %b want 010", gnt_v); end
    step();
    // Lock with D dropping its request: the port must idle, not serve I.
    bus.d_req = 1; bus.d_lock = 1; bus.d_addr = 32'h40;
    #1;
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL lock2_d: got %b want 001", gnt_v); end
    step();
    bus.d_req = 0; bus.d_lock = 0;
    #1;
    checks++; if (gnt_v !== 3'b000) begin errors++; $display("FAIL lock_idle: got %b want 000", gnt_v); end
    checks++; if (bus.mem_ce !== 1'b0) begin errors++; $display("FAIL lock_idle_ce: got %b want 0", bus.mem_ce); end
    step();
    #1;
    checks++; if (gnt_v !== 3'b010) begin errors++; $display("FAIL lock_release_i: got %b want 010", gnt_v); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_aging();
    logic [2:0] exp_g;
    bus.d_req = 1; bus.d_addr = 32'h10;
    bus.x_req = 1; bus.x_addr = 32'h300;
    for (int c = 1; c <= 2 * (MAX_WAIT + 1); c++) begin
      exp_g = (c % (MAX_WAIT + 1) == 0) ? 3'b100 : 3'b001;
      #1;
      checks++; if (gnt_v !== exp_g) begin errors++; $display("FAIL aging_gnt cycle %0d: got %b want %b", c, gnt_v, exp_g); end
      step();
      checks++; if (rv_v !== exp_g) begin errors++; $display("FAIL aging_rvalid cycle %0d: got %b want %b", c, rv_v, exp_g); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write();
    bus.x_req = 1; bus.x_addr = 32'h40; bus.x_we = 4'b0011; bus.x_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (gnt_v !== 3'b100) begin errors++; $display("FAIL wr_gnt: got %b want 100", gnt_v); end
    checks++; if (bus.mem_we !== 4'b0011) begin errors++; $display("FAIL wr_we: got %b want 0011", bus.mem_we); end
    checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata: got %h want deadbeef", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("FAIL wr_addr: got %h want 40", bus.mem_addr); end
    step();
    idle_inputs();
    checks++; if (rv_v !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid: got %b want 000", rv_v); end
    step();
  endtask

  task automatic test_pipeline();
    bus.i_req = 1; bus.i_addr = 32'h0;
    #1;
    checks++; if (gnt_v !== 3'b010) begin errors++; $display("FAIL pipe_gnt_i: got %b want 010", gnt_v); end
    step();
    idle_inputs(); bus.d_req = 1; bus.d_addr = 32'h8;
    checks++; if (rv_v !== 3'b010) begin errors++; $display("FAIL pipe_rv_i: got %b want 010", rv_v); end
    checks++; if (bus.rdata !== pat(32'h0)) begin errors++; $display("FAIL pipe_rdata_i: got %h want %h", bus.rdata, pat(32'h0)); end
    #1;
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL pipe_gnt_d: got %b want 001", gnt_v); end
    step();
    idle_inputs(); bus.x_req = 1; bus.x_addr = 32'hC;
    checks++; if (rv_v !== 3'b001) begin errors++; $display("FAIL pipe_rv_d: got %b want 001", rv_v); end
    checks++; if (bus.rdata !== pat(32'h8)) begin errors++; $display("FAIL pipe_rdata_d: got %h want %h", bus.rdata, pat(32'h8)); end
    #1;
    checks++; if (gnt_v !== 3'b100) begin errors++; $display("FAIL pipe_gnt_x: got %b want 100", gnt_v); end
    step();
    idle_inputs();
    checks++; if (rv_v !== 3'b100) begin errors++; $display("FAIL pipe_rv_x: got %b want 100", rv_v); end
    checks++; if (bus.rdata !== pat(32'hC)) begin errors++; $display("FAIL pipe_rdata_x: got %h want %h", bus.rdata, pat(32'hC)); end
    step();
    checks++; if (rv_v !== 3'b000) begin errors++; $display("FAIL pipe_rv_end: got %b want 000", rv_v); end
  endtask

  task automatic test_async_reset();
    bus.d_req = 1; bus.d_lock = 1; bus.d_addr = 32'h20;
    bus.i_req = 1; bus.i_addr = 32'h200;
    #1;
    checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL arst_lock_gnt: got %b want 001", gnt_v); end
    step();
    bus.d_req = 0; bus.d_lock = 0;
    checks++; if (rv_v !== 3'b001) begin errors++; $display("FAIL arst_pending: got %b want 001", rv_v); end
    #1;
    checks++; if (gnt_v !== 3'b000) begin errors++; $display("FAIL arst_locked_idle: got %b want 000", gnt_v); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rv_v !== 3'b000) begin errors++; $display("FAIL arst_rvalid_lost: got %b want 000", rv_v); end
    checks++; if (gnt_v !== 3'b010) begin errors++; $display("FAIL arst_lock_cleared: got %b want 010", gnt_v); end
    rst = 1'b0;
    #1;
    checks++; if (gnt_v !== 3'b010) begin errors++; $display("FAIL arst_after_i: got %b want 010", gnt_v); end
    step();
    idle_inputs();
    checks++; if (rv_v !== 3'b010) begin errors++; $display("FAIL arst_i_rv: got %b want 010", rv_v); end
    checks++; if (bus.rdata !== pat(32'h200)) begin errors++; $display("FAIL arst_i_rdata: got %h want %h", bus.rdata, pat(32'h200)); end
    step();
  endtask

  // Reference model: requesters hold until granted; the arbiter is judged on
  // grant choice, port drive and next-cycle tagged read return.
  task automatic test_random(input int n);
    int          g, g_prev, m_pending, m_denied;
    bit          m_locked;
    logic [31:0] m_pend_addr, ea, ew;
    logic [3:0]  ewe;
    g_prev = 0; m_pending = 0; m_denied = 0; m_locked = 0; m_pend_addr = '0;
    for (int c = 0; c < n; c++) begin
      checks++; if (rv_v !== oh(m_pending)) begin errors++; $display("FAIL rnd_rvalid cycle %0d: got %b want %b", c, rv_v, oh(m_pending)); end
      if (m_pending != 0) begin
        checks++; if (bus.rdata !== pat(m_pend_addr)) begin errors++; $display("FAIL rnd_rdata cycle %0d: got %h want %h", c, bus.rdata, pat(m_pend_addr)); end
      end
      if (!bus.d_req || g_prev == 1) begin
        bus.d_req   = ($urandom_range(0, 9) < 6);
        bus.d_addr  = 32'($urandom_range(0, 255)) << 2;
        bus.d_wdata = $urandom();
        bus.d_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        bus.d_lock  = bus.d_req && ($urandom_range(0, 3) == 0);
      end
      if (!bus.i_req || g_prev == 2) begin
        bus.i_req  = ($urandom_range(0, 1) == 1);
        bus.i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!bus.x_req || g_prev == 3) begin
        bus.x_req   = ($urandom_range(0, 9) < 4);
        bus.x_addr  = 32'($urandom_range(0, 255)) << 2;
        bus.x_wdata = $urandom();
        bus.x_we    = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      #1;
      if (m_locked)                              g = bus.d_req ? 1 : 0;
      else if (bus.x_req && m_denied >= MAX_WAIT) g = 3;
      else if (bus.d_req)                        g = 1;
      else if (bus.i_req)                        g = 2;
      else if (bus.x_req)                        g = 3;
      else                                       g = 0;
      case (g)
        1:       begin ea = bus.d_addr; ew = bus.d_wdata; ewe = bus.d_we; end
        2:       begin ea = bus.i_addr; ew = '0;          ewe = '0;       end
        3:       begin ea = bus.x_addr; ew = bus.x_wdata; ewe = bus.x_we; end
        default: begin ea = '0;         ew = '0;          ewe = '0;       end
      endcase
      checks++; if (gnt_v !== oh(g)) begin errors++; $display("FAIL rnd_gnt cycle %0d: got %b want %b", c, gnt_v, oh(g)); end
      checks++; if (bus.mem_ce !== (g != 0)) begin errors++; $display("FAIL rnd_ce cycle %0d: got %b want %b", c, bus.mem_ce, (g != 0)); end
      checks++; if (bus.mem_addr !== ea) begin errors++; $display("FAIL rnd_addr cycle %0d: got %h want %h", c, bus.mem_addr, ea); end
      checks++; if (bus.mem_wdata !== ew) begin errors++; $display("FAIL rnd_wdata cycle %0d: got %h want %h", c, bus.mem_wdata, ew); end
      checks++; if (bus.mem_we !== ewe) begin errors++; $display("FAIL rnd_we cycle %0d: got %b want %b", c, bus.mem_we, ewe); end
      m_pending   = (g != 0 && ewe == 4'h0) ? g : 0;
      m_pend_addr = ea;
      m_locked    = (g == 1) && bus.d_lock;
      m_denied    = (bus.x_req && g != 3) ? ((m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT) : 0;
      g_prev      = g;
      step();
    end
    checks++; if (rv_v !== oh(m_pending)) begin errors++; $display("FAIL rnd_rvalid_last: got %b want %b", rv_v, oh(m_pending)); end
    idle_inputs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_priority();
    test_lock();
    test_aging();
    test_write();
    test_pipeline();
    test_async_reset();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
